// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the inter-stage pipeline register: slot state
// encodings, per-cycle action decode and legacy control constants.
package pipe_stage_reg_pkg;

   // Legacy control constants carried over from define.v
   localparam logic        STOP       = 1'b1;
   localparam logic        NO_STOP    = 1'b0;
   localparam logic        RST_ENABLE = 1'b1;
   localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

   // Slot status as seen on the state output
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_RUN   = 2'd1,
      ST_HOLD  = 2'd2
   } slot_state_t;

   // What the slot does on a given (non-reset) cycle
   typedef enum logic [1:0] {
      ACT_FLUSH   = 2'd0,
      ACT_BUBBLE  = 2'd1,
      ACT_ADVANCE = 2'd2,
      ACT_HOLD    = 2'd3
   } slot_action_t;

   // Flush beats any stall; su=0 always advances (su=0/sd=1 is folded in here)
   function automatic slot_action_t decode_action(input logic flush,
                                                  input logic su,
                                                  input logic sd);
      slot_action_t act;
      if (flush)
         act = ACT_FLUSH;
      else if (su == NO_STOP)
         act = ACT_ADVANCE;
      else if (sd == STOP)
         act = ACT_HOLD;
      else
         act = ACT_BUBBLE;
      return act;
   endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous reset and clear.
module sat_counter
   import pipe_stage_reg_pkg::*;
#(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   // Count qualifying events, stick at all-ones, clear overrides increment
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE || clr)
         q <= '0;
      else if (inc && (q != '1))
         q <= q + 1'b1;
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline register between stage STAGE and STAGE+1 with
// flush, held-slot status and saturating stall/bubble/flush counters.
module pipe_stage_reg
   import pipe_stage_reg_pkg::*;
#(
   parameter int unsigned          DATA_W     = 64,
   parameter int unsigned          STALL_W    = 6,
   parameter int unsigned          STAGE      = 1,
   parameter logic [DATA_W-1:0]    BUBBLE_VAL = DATA_W'(ZERO_WORD),
   parameter int unsigned          CNT_W      = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall,
   input  logic               flush,
   input  logic               in_valid,
   input  logic [DATA_W-1:0]  in_data,
   input  logic               cnt_clr,
   output logic               out_valid,
   output logic [DATA_W-1:0]  out_data,
   output logic [1:0]         state,
   output logic [CNT_W-1:0]   stall_cnt,
   output logic [CNT_W-1:0]   bubble_cnt,
   output logic [CNT_W-1:0]   flush_cnt
);

   if (STAGE + 1 >= STALL_W) begin : g_bad_stage
      $fatal(1, "pipe_stage_reg: STAGE+1 (%0d) must be below STALL_W (%0d)",
             STAGE + 1, STALL_W);
   end

   logic              su;
   logic              sd;
   slot_action_t      act;
   slot_state_t       state_q;
   slot_state_t       state_d;
   logic              valid_q;
   logic              valid_d;
   logic [DATA_W-1:0] data_q;
   logic [DATA_W-1:0] data_d;
   logic              hold_inc;
   logic              bubble_inc;
   logic              flush_inc;

   // Pick this slot's two bits out of the global stall vector
   always_comb begin
      su = 1'b0;
      sd = 1'b0;
      for (int unsigned i = 0; i < STALL_W; i++) begin
         if (i == STAGE)
            su = stall[i];
         if (i == STAGE + 1)
            sd = stall[i];
      end
   end

   // Next slot contents, status and counter events for this cycle
   always_comb begin
      act        = decode_action(flush, su, sd);
      state_d    = state_q;
      valid_d    = valid_q;
      data_d     = data_q;
      hold_inc   = 1'b0;
      bubble_inc = 1'b0;
      flush_inc  = 1'b0;
      case (act)
         ACT_FLUSH: begin
            valid_d   = 1'b0;
            data_d    = BUBBLE_VAL;
            state_d   = ST_EMPTY;
            flush_inc = valid_q;
         end
         ACT_BUBBLE: begin
            valid_d    = 1'b0;
            data_d     = BUBBLE_VAL;
            state_d    = ST_EMPTY;
            bubble_inc = 1'b1;
         end
         ACT_ADVANCE: begin
            valid_d = in_valid;
            data_d  = in_data;
            state_d = in_valid ? ST_RUN : ST_EMPTY;
         end
         ACT_HOLD: begin
            state_d  = valid_q ? ST_HOLD : ST_EMPTY;
            hold_inc = valid_q;
         end
         default: begin
            state_d = ST_EMPTY;
         end
      endcase
   end

   // Slot state, valid and payload registers
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         state_q <= ST_EMPTY;
         valid_q <= 1'b0;
         data_q  <= BUBBLE_VAL;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign state     = state_q;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .inc (hold_inc),
      .q   (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_bubble_cnt (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .inc (bubble_inc),
      .q   (bubble_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .inc (flush_inc),
      .q   (flush_cnt)
   );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: default instance, a 3-bit counter
// instance for saturation, and a DATA_W=32/STAGE=3 instance.
module tb_pipe_stage_reg;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   errors = 0;

   // Main instance (defaults)
   logic [5:0]  stall_m = '0;
   logic        flush_m = 1'b0;
   logic        valid_m = 1'b0;
   logic [63:0] data_m  = '0;
   logic        clr_m   = 1'b0;
   logic        ov_m;
   logic [63:0] od_m;
   logic [1:0]  st_m;
   logic [31:0] sc_m, bc_m, fc_m;

   // Saturation instance (CNT_W=3)
   logic [5:0]  stall_s = '0;
   logic        clr_s   = 1'b0;
   logic        ov_s;
   logic [63:0] od_s;
   logic [1:0]  st_s;
   logic [2:0]  sc_s, bc_s, fc_s;

   // Sweep instance (DATA_W=32, STAGE=3)
   logic [5:0]  stall_w = '0;
   logic        valid_w = 1'b0;
   logic [31:0] data_w  = '0;
   logic        ov_w;
   logic [31:0] od_w;
   logic [1:0]  st_w;
   logic [31:0] sc_w, bc_w, fc_w;

   pipe_stage_reg u_dut (
      .clk (clk), .rst (rst), .stall (stall_m), .flush (flush_m),
      .in_valid (valid_m), .in_data (data_m), .cnt_clr (clr_m),
      .out_valid (ov_m), .out_data (od_m), .state (st_m),
      .stall_cnt (sc_m), .bubble_cnt (bc_m), .flush_cnt (fc_m)
   );

   pipe_stage_reg #(.CNT_W(3)) u_sat (
      .clk (clk), .rst (rst), .stall (stall_s), .flush (1'b0),
      .in_valid (1'b1), .in_data (64'h5555_AAAA_5555_AAAA), .cnt_clr (clr_s),
      .out_valid (ov_s), .out_data (od_s), .state (st_s),
      .stall_cnt (sc_s), .bubble_cnt (bc_s), .flush_cnt (fc_s)
   );

   pipe_stage_reg #(.DATA_W(32), .STAGE(3), .STALL_W(6)) u_sweep (
      .clk (clk), .rst (rst), .stall (stall_w), .flush (1'b0),
      .in_valid (valid_w), .in_data (data_w), .cnt_clr (1'b0),
      .out_valid (ov_w), .out_data (od_w), .state (st_w),
      .stall_cnt (sc_w), .bubble_cnt (bc_w), .flush_cnt (fc_w)
   );

   always #5 clk = ~clk;

   // The stall controller must never raise sd without su on the main slot
   always @(negedge clk) begin
      if (!rst)
         assert (!(!stall_m[1] && stall_m[2]))
            else $error("FAIL illegal_stall got=%b", stall_m);
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h required=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_main(input string tag, input logic v,
                             input logic [63:0] d, input logic [1:0] s,
                             input logic [31:0] sc, input logic [31:0] bc,
                             input logic [31:0] fc);
      check({tag, ".valid"}, 64'(ov_m), 64'(v));
      check({tag, ".data"},  od_m, d);
      check({tag, ".state"}, 64'(st_m), 64'(s));
      check({tag, ".stall_cnt"},  64'(sc_m), 64'(sc));
      check({tag, ".bubble_cnt"}, 64'(bc_m), 64'(bc));
      check({tag, ".flush_cnt"},  64'(fc_m), 64'(fc));
   endtask

   initial begin
      // Reset with a live payload upstream
      rst = 1'b1; valid_m = 1'b1; data_m = 64'hDEADBEEF_00400000;
      tick();
      check_main("rst1", 1'b0, 64'h0, 2'd0, 0, 0, 0);
      tick();
      check_main("rst2", 1'b0, 64'h0, 2'd0, 0, 0, 0);

      rst = 1'b0;
      tick();
      check_main("first_adv", 1'b1, 64'hDEADBEEF_00400000, 2'd1, 0, 0, 0);

      // Bubble: upstream payload must not be captured
      stall_m = 6'b000010; data_m = 64'h1111_2222_3333_4444;
      tick();
      check_main("bubble", 1'b0, 64'h0, 2'd0, 0, 1, 0);

      stall_m = 6'b000000; data_m = 64'h0000_0001_0000_0040;
      tick();
      check_main("adv_a", 1'b1, 64'h0000_0001_0000_0040, 2'd1, 0, 1, 0);

      // Hold three cycles while upstream keeps changing
      stall_m = 6'b000110;
      for (int i = 1; i <= 3; i++) begin
         data_m = 64'hF0F0_0000_0000_0000 + 64'(i);
         tick();
         check_main("hold", 1'b1, 64'h0000_0001_0000_0040, 2'd2, 32'(i), 1, 0);
      end

      // Flush wins over hold
      flush_m = 1'b1;
      tick();
      check_main("flush_hold", 1'b0, 64'h0, 2'd0, 3, 1, 1);

      // Hold of an empty slot does not count
      flush_m = 1'b0;
      tick();
      check_main("hold_empty", 1'b0, 64'h0, 2'd0, 3, 1, 1);

      // Advance of an invalid slot still carries the payload
      stall_m = 6'b000000; valid_m = 1'b0; data_m = 64'h0BAD_0BAD_0BAD_0BAD;
      tick();
      check_main("adv_inv", 1'b0, 64'h0BAD_0BAD_0BAD_0BAD, 2'd0, 3, 1, 1);

      // Flush of an invalid slot does not count
      flush_m = 1'b1;
      tick();
      check_main("flush_inv", 1'b0, 64'h0, 2'd0, 3, 1, 1);

      flush_m = 1'b0; valid_m = 1'b1; data_m = 64'hBBBB_0000_0000_000B;
      tick();
      check_main("adv_b", 1'b1, 64'hBBBB_0000_0000_000B, 2'd1, 3, 1, 1);

      // Clear leaves the slot alone
      clr_m = 1'b1; data_m = 64'hCCCC_0000_0000_000C;
      tick();
      check_main("clr_adv", 1'b1, 64'hCCCC_0000_0000_000C, 2'd1, 0, 0, 0);

      clr_m = 1'b0; stall_m = 6'b000110;
      tick();
      check_main("hold_c", 1'b1, 64'hCCCC_0000_0000_000C, 2'd2, 1, 0, 0);

      // Reset mid-hold discards the held payload
      rst = 1'b1;
      tick();
      check_main("rst_hold", 1'b0, 64'h0, 2'd0, 0, 0, 0);
      rst = 1'b0; stall_m = 6'b000000; valid_m = 1'b0; data_m = '0;
      tick();

      // Saturation on a 3-bit bubble counter
      stall_s = 6'b000010;
      for (int i = 1; i <= 9; i++) begin
         tick();
         check("sat_bubble", 64'(bc_s), (i < 7) ? 64'(i) : 64'd7);
      end
      check("sat_valid", 64'(ov_s), 64'd0);
      clr_s = 1'b1;
      tick();
      check("sat_clr", 64'(bc_s), 64'd0);
      clr_s = 1'b0;
      tick();
      check("sat_after_clr", 64'(bc_s), 64'd1);
      stall_s = 6'b000000;

      // STAGE=3 decodes only bits 3/4
      stall_w = 6'b010000; valid_w = 1'b1; data_w = 32'hCAFE_F00D;
      tick();
      check("sweep_adv.data",  64'(od_w), 64'hCAFE_F00D);
      check("sweep_adv.valid", 64'(ov_w), 64'd1);
      check("sweep_adv.state", 64'(st_w), 64'd1);
      stall_w = 6'b100111; data_w = 32'h1234_5678;
      tick();
      check("sweep_other.data", 64'(od_w), 64'h1234_5678);
      check("sweep_other.state", 64'(st_w), 64'd1);
      stall_w = 6'b011000; data_w = 32'h8765_4321;
      tick();
      check("sweep_hold.data",  64'(od_w), 64'h1234_5678);
      check("sweep_hold.state", 64'(st_w), 64'd2);
      check("sweep_hold.cnt",   64'(sc_w), 64'd1);
      stall_w = 6'b001000;
      tick();
      check("sweep_bubble.valid", 64'(ov_w), 64'd0);
      check("sweep_bubble.data",  64'(od_w), 64'h0);
      check("sweep_bubble.cnt",   64'(bc_w), 64'd1);
      stall_w = 6'b000000;

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
